// File: rtl/johnson_decoder.sv
// Johnson-code decoder: validates each sampled code, tracks its sequence and reports errors.
// Optional saturating error counter is built when JOHNSON_DECODER_ERRCNT_EN is defined.
module johnson_decoder #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CW    = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] code_in,
   input  logic             code_vld,
   input  logic             clr_err,
   output logic [CW-1:0]    count,
   output logic             count_vld,
   output logic             locked,
   output logic             code_err,
   output logic             seq_err,
   output logic             wrap,
   output logic [7:0]       err_cnt
);

   localparam int unsigned   Len     = 2 * WIDTH;
   localparam logic [CW-1:0] LastIdx = CW'(Len - 1);

   typedef enum logic {StUnlocked, StLocked} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          count_vld_q, count_vld_d;
   logic          code_err_q, code_err_d;
   logic          seq_err_q, seq_err_d;
   logic          wrap_q, wrap_d;

   logic          legal;
   logic [CW-1:0] idx;
   logic [CW-1:0] nxt_idx;

   // A legal Johnson code has at most one change between adjacent bits.
   always_comb begin
      int unsigned trans;
      int unsigned ones;
      trans = 0;
      ones  = 0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (code_in[i] != code_in[i+1]) trans++;
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (code_in[i]) ones++;
      end
      legal = (trans <= 1);
      if (code_in[WIDTH-1] || (ones == 0)) idx = CW'(ones);
      else                                  idx = CW'(Len - ones);
   end

   assign nxt_idx = (count_q == LastIdx) ? '0 : count_q + CW'(1);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      count_vld_d = 1'b0;
      code_err_d  = 1'b0;
      seq_err_d   = 1'b0;
      wrap_d      = 1'b0;
      if (code_vld) begin
         if (!legal) begin
            code_err_d = 1'b1;
            state_d    = StUnlocked;
         end else begin
            count_d     = idx;
            count_vld_d = 1'b1;
            state_d     = StLocked;
            unique case (state_q)
               StUnlocked: ;
               StLocked: begin
                  if (idx == nxt_idx) wrap_d    = (count_q == LastIdx);
                  else                seq_err_d = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StUnlocked;
         count_q     <= '0;
         count_vld_q <= 1'b0;
         code_err_q  <= 1'b0;
         seq_err_q   <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         count_vld_q <= count_vld_d;
         code_err_q  <= code_err_d;
         seq_err_q   <= seq_err_d;
         wrap_q      <= wrap_d;
      end
   end

   assign count     = count_q;
   assign count_vld = count_vld_q;
   assign locked    = (state_q == StLocked);
   assign code_err  = code_err_q;
   assign seq_err   = seq_err_q;
   assign wrap      = wrap_q;

`ifdef JOHNSON_DECODER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       err_event;

   // A clear coinciding with an error keeps that error counted.
   always_comb begin
      err_event = code_err_d | seq_err_d;
      err_cnt_d = err_cnt_q;
      if (clr_err) begin
         err_cnt_d = {7'd0, err_event};
      end else if (err_event && (err_cnt_q != 8'hff)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt_q <= 8'd0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_clr_err;
   assign unused_clr_err = clr_err;
   assign err_cnt        = 8'd0;
`endif

endmodule
